// File: rtl/pc_source_select_if.sv
// rtl/pc_source_select_if.sv - candidate/control inputs and PC outputs of the fetch PC selector
interface pc_source_select_if #(
    parameter int bus_size = 10,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = 2
);
    logic [NUM_SRC*bus_size-1:0] in_flat;
    logic [SEL_W-1:0]            sel;
    logic                        redirect;
    logic                        stall;
    logic [bus_size-1:0]         pc_out;
    logic                        pc_valid;
    logic                        redirect_pending;
    logic                        sel_err;

    modport master (
        output in_flat, sel, redirect, stall,
        input  pc_out, pc_valid, redirect_pending, sel_err
    );

    modport slave (
        input  in_flat, sel, redirect, stall,
        output pc_out, pc_valid, redirect_pending, sel_err
    );
endinterface

// File: rtl/pc_source_select.sv
// rtl/pc_source_select.sv - registered fetch PC: sequential advance, N-way redirect, stall hold
// Redirects seen while stalled are parked in a one-entry buffer and applied when the stall lifts.
module pc_source_select #(
    parameter int bus_size  = 10,
    parameter int NUM_SRC   = 4,
    parameter int SEL_W     = 2,
    parameter int RESET_VAL = 0,
    parameter int INC       = 1
) (
    input  logic             clk,
    input  logic             reset,
    pc_source_select_if.slave bus
);
    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [bus_size-1:0] RESET_PC = RESET_VAL[bus_size-1:0];
    localparam logic [bus_size-1:0] INC_W    = INC[bus_size-1:0];
    localparam logic [SEL_W:0]      NUM_SRC_W = NUM_SRC[SEL_W:0];

    state_t              state;
    logic [bus_size-1:0] pc;
    logic [bus_size-1:0] pend_addr;
    logic                valid_q;
    logic                err_q;
    logic                sel_ok;
    logic                legal;
    logic [bus_size-1:0] sel_addr;

    assign sel_ok = ({1'b0, bus.sel} < NUM_SRC_W);
    assign legal  = bus.redirect && sel_ok;

    // Explicit compare-mux so an out-of-range sel never indexes past in_flat.
    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.sel == k[SEL_W-1:0])
                sel_addr = bus.in_flat[k*bus_size +: bus_size];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            pend_addr <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            err_q   <= bus.redirect && !sel_ok;
            if (bus.stall) begin
                if (legal) begin
                    pend_addr <= sel_addr;
                    state     <= PEND;
                end
            end else if (legal) begin
                pc    <= sel_addr;
                state <= IDLE;
            end else if (state == PEND) begin
                pc    <= pend_addr;
                state <= IDLE;
            end else begin
                pc <= pc + INC_W;
            end
        end
    end

    assign bus.pc_out           = pc;
    assign bus.pc_valid         = valid_q;
    assign bus.redirect_pending = (state == PEND);
    assign bus.sel_err          = err_q;
endmodule

// File: tb/tb_pc_source_select.sv
// tb/tb_pc_source_select.sv - scoreboard bench for pc_source_select with 4-source and 3-source instances
module tb_pc_source_select;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [9:0] src [4];
    logic [1:0] sel;
    logic       redirect;
    logic       stall;

    pc_source_select_if #(.bus_size(10), .NUM_SRC(4), .SEL_W(2)) bus4 ();
    pc_source_select_if #(.bus_size(10), .NUM_SRC(3), .SEL_W(2)) bus3 ();

    assign bus4.in_flat  = {src[3], src[2], src[1], src[0]};
    assign bus4.sel      = sel;
    assign bus4.redirect = redirect;
    assign bus4.stall    = stall;
    assign bus3.in_flat  = {src[2], src[1], src[0]};
    assign bus3.sel      = sel;
    assign bus3.redirect = redirect;
    assign bus3.stall    = stall;

    pc_source_select #(.bus_size(10), .NUM_SRC(4), .SEL_W(2), .RESET_VAL(0), .INC(1)) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4));
    pc_source_select #(.bus_size(10), .NUM_SRC(3), .SEL_W(2), .RESET_VAL(0), .INC(1)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3));

    typedef struct {
        logic [9:0] pc;
        logic [9:0] pend;
        logic       pending;
        logic       valid;
        logic       err;
    } mdl_t;

    typedef struct {
        mdl_t e4;
        mdl_t e3;
    } exp_t;

    mdl_t m4, m3;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic mdl_t step(input mdl_t m, input int nsrc);
        mdl_t n = m;
        bit   ok = (int'(sel) < nsrc);
        bit   lg = redirect && ok;
        if (reset) begin
            n.pc = 10'd0; n.pend = 10'd0; n.pending = 1'b0; n.valid = 1'b0; n.err = 1'b0;
            return n;
        end
        n.valid = 1'b1;
        n.err   = redirect && !ok;
        if (stall) begin
            if (lg) begin n.pend = src[sel]; n.pending = 1'b1; end
        end else if (lg) begin
            n.pc = src[sel]; n.pending = 1'b0;
        end else if (m.pending) begin
            n.pc = m.pend; n.pending = 1'b0;
        end else begin
            n.pc = m.pc + 10'd1;
        end
        return n;
    endfunction

    task automatic tick();
        exp_t e;
        m4 = step(m4, 4);
        m3 = step(m3, 3);
        e.e4 = m4;
        e.e3 = m3;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc4",   32'(bus4.pc_out),           32'(e.e4.pc));
        check("val4",  32'(bus4.pc_valid),         32'(e.e4.valid));
        check("pend4", 32'(bus4.redirect_pending), 32'(e.e4.pending));
        check("err4",  32'(bus4.sel_err),          32'(e.e4.err));
        check("pc3",   32'(bus3.pc_out),           32'(e.e3.pc));
        check("val3",  32'(bus3.pc_valid),         32'(e.e3.valid));
        check("pend3", 32'(bus3.redirect_pending), 32'(e.e3.pending));
        check("err3",  32'(bus3.sel_err),          32'(e.e3.err));
    endtask

    task automatic drive(input logic r, input logic st, input logic rd, input logic [1:0] s);
        reset = r; stall = st; redirect = rd; sel = s;
        tick();
    endtask

    initial begin
        m4 = '{10'd0, 10'd0, 1'b0, 1'b0, 1'b0};
        m3 = m4;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; sel = 2'd0;
        for (int i = 0; i < 4; i++) src[i] = 10'd0;

        // Reset and sequential advance
        drive(1, 0, 0, 0);
        check("t1_rst_pc", 32'(bus4.pc_out), 32'h0);
        check("t1_rst_valid", 32'(bus4.pc_valid), 32'h0);
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0);
            check("t1_pc", 32'(bus4.pc_out), 32'(i));
            check("t1_valid", 32'(bus4.pc_valid), 32'h1);
        end

        // Live redirect
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("t2_pc5", 32'(bus4.pc_out), 32'h5);
        src[2] = 10'h1A0;
        drive(0, 0, 1, 2);
        check("t2_redir", 32'(bus4.pc_out), 32'h1A0);
        drive(0, 0, 0, 0);
        check("t2_inc", 32'(bus4.pc_out), 32'h1A1);

        // Stalled redirect, source changed after buffering
        src[0] = 10'h008;
        drive(0, 0, 1, 0);
        src[1] = 10'h040;
        drive(0, 1, 1, 1);
        src[1] = 10'h2AA;
        drive(0, 1, 0, 1);
        drive(0, 1, 0, 1);
        check("t3_hold", 32'(bus4.pc_out), 32'h8);
        check("t3_pend", 32'(bus4.redirect_pending), 32'h1);
        drive(0, 0, 0, 0);
        check("t3_release", 32'(bus4.pc_out), 32'h040);
        check("t3_clear", 32'(bus4.redirect_pending), 32'h0);

        // Overwrite then live redirect beats buffer
        src[1] = 10'h040;
        drive(0, 1, 1, 1);
        src[3] = 10'h3F0;
        drive(0, 1, 1, 3);
        src[3] = 10'h155;
        src[0] = 10'h111;
        drive(0, 0, 1, 0);
        check("t4_live", 32'(bus4.pc_out), 32'h111);
        check("t4_clear", 32'(bus4.redirect_pending), 32'h0);
        drive(0, 0, 0, 0);
        check("t4_no3f0", 32'(bus4.pc_out == 10'h3F0), 32'h0);

        // Wrap and out-of-range select on the 3-source instance
        src[0] = 10'h3FF;
        drive(0, 0, 1, 0);
        src[3] = 10'h0AB;
        drive(0, 0, 1, 3);
        check("t5_wrap", 32'(bus3.pc_out), 32'h0);
        check("t5_err", 32'(bus3.sel_err), 32'h1);
        drive(0, 0, 0, 0);
        check("t5_err_pulse", 32'(bus3.sel_err), 32'h0);

        // Reset mid-stall with a pending redirect
        src[1] = 10'h077;
        drive(0, 1, 1, 1);
        drive(1, 1, 0, 0);
        check("t6_pc", 32'(bus4.pc_out), 32'h0);
        check("t6_pend", 32'(bus4.redirect_pending), 32'h0);
        check("t6_valid", 32'(bus4.pc_valid), 32'h0);
        drive(0, 0, 0, 0);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) src[$urandom_range(0, 3)] = 10'($urandom);
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
